// File: rtl/store_seq_pkg.sv
// Shared types and helpers for the store sequencer.
package store_seq_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REQ_ADDR_W = 64;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } st_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } seq_state_e;

    // addr is held at the widest supported width; size keeps the raw 2-bit code so 2'b11 survives.
    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [1:0]            size;
    } st_req_t;

    function automatic logic [7:0] size_to_be8(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            default: return 8'h0F;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment: byte-enables and data shifted into a two-word window.
module store_lane_align
    import store_seq_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_data,
    output logic [7:0]  o_be8,
    output logic [63:0] o_data64
);

    assign o_be8    = size_to_be8(i_size) << i_off;
    assign o_data64 = {32'b0, i_data} << {i_off, 3'b000};

endmodule

// File: rtl/store_sequencer.sv
// Store-path sequencer: request FIFO feeding a word-aligned memory write port.
// Build option STORE_SEQ_MISALIGN_SPLIT_EN splits word-crossing stores into two beats.
module store_sequencer
    import store_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              busy,
    output logic              misalign_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    st_req_t           r_fifo [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    st_req_t           w_head;
    logic [ADDR_W-1:0] w_head_addr;
    logic [7:0]        w_be8;
    logic [63:0]       w_data64;
    logic              w_mis;
    logic              w_unused_bits;

    seq_state_e        r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_err;

    seq_state_e        w_nxt_state;
    logic              w_nxt_req;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [31:0]       w_nxt_wdata;
    logic [3:0]        w_nxt_be;
    logic              w_nxt_err;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = st_valid && !w_full;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_head_addr = w_head.addr[ADDR_W-1:0];
    assign w_mis       = |w_be8[7:4];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{addr: REQ_ADDR_W'(st_addr), data: st_data, size: st_size};
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    store_lane_align u_align (
        .i_off    (w_head_addr[1:0]),
        .i_size   (w_head.size),
        .i_data   (w_head.data),
        .o_be8    (w_be8),
        .o_data64 (w_data64)
    );

`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
    logic        r_split;
    logic [3:0]  r_be1;
    logic [31:0] r_wd1;
    logic        w_nxt_split;
    logic [3:0]  w_nxt_be1;
    logic [31:0] w_nxt_wd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_split <= 1'b0;
            r_be1   <= '0;
            r_wd1   <= '0;
        end else begin
            r_split <= w_nxt_split;
            r_be1   <= w_nxt_be1;
            r_wd1   <= w_nxt_wd1;
        end
    end

    assign misalign_err  = 1'b0;
    assign w_unused_bits = ^{w_head.addr, r_err};
`else
    assign misalign_err  = r_err;
    assign w_unused_bits = ^{w_head.addr, w_data64[63:32]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_req   <= w_nxt_req;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_wdata;
            r_be    <= w_nxt_be;
            r_err   <= w_nxt_err;
        end
    end

    // Next beat selection; everything holds unless idle or the current beat is granted.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_req   = r_req;
        w_nxt_addr  = r_addr;
        w_nxt_wdata = r_wdata;
        w_nxt_be    = r_be;
        w_nxt_err   = 1'b0;
        w_pop       = 1'b0;
`ifdef STORE_SEQ_MISALIGN_SPLIT_EN
        w_nxt_split = r_split;
        w_nxt_be1   = r_be1;
        w_nxt_wd1   = r_wd1;
        if ((r_state == IDLE) || mem_gnt) begin
            if ((r_state == BEAT0) && r_split) begin
                w_nxt_state = BEAT1;
                w_nxt_req   = 1'b1;
                w_nxt_addr  = r_addr + ADDR_W'(4);
                w_nxt_be    = r_be1;
                w_nxt_wdata = r_wd1;
                w_nxt_split = 1'b0;
            end else if (!w_empty) begin
                w_pop       = 1'b1;
                w_nxt_state = BEAT0;
                w_nxt_req   = 1'b1;
                w_nxt_addr  = {w_head_addr[ADDR_W-1:2], 2'b00};
                w_nxt_be    = w_be8[3:0];
                w_nxt_wdata = w_data64[31:0];
                w_nxt_split = w_mis;
                w_nxt_be1   = w_be8[7:4];
                w_nxt_wd1   = w_data64[63:32];
            end else begin
                w_nxt_state = IDLE;
                w_nxt_req   = 1'b0;
                w_nxt_split = 1'b0;
            end
        end
`else
        if ((r_state == IDLE) || mem_gnt) begin
            if (!w_empty) begin
                w_pop = 1'b1;
                if (w_mis) begin
                    w_nxt_err   = 1'b1;
                    w_nxt_state = IDLE;
                    w_nxt_req   = 1'b0;
                end else begin
                    w_nxt_state = BEAT0;
                    w_nxt_req   = 1'b1;
                    w_nxt_addr  = {w_head_addr[ADDR_W-1:2], 2'b00};
                    w_nxt_be    = w_be8[3:0];
                    w_nxt_wdata = w_data64[31:0];
                end
            end else begin
                w_nxt_state = IDLE;
                w_nxt_req   = 1'b0;
            end
        end
`endif
    end

    assign st_ready  = !w_full;
    assign mem_req   = r_req;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign busy      = !w_empty || (r_state != IDLE);

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (r_req && !mem_gnt) |=> (r_req && $stable(r_addr) && $stable(r_wdata) && $stable(r_be)));

endmodule
